// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared FSM type and constants for the AXI4-Lite SRAM bridge
package sram_ctrl_pkg;
    typedef enum logic [2:0] {
        IDLE, WR_SETUP, WR_PULSE, WR_HOLD, RD_STROBE, B_RESP, R_RESP
    } state_t;
    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam int WAIT_DEFAULT = 1;
    localparam int CNT_W = 4;
endpackage

// File: rtl/sram_axil_bridge.sv
// sram_axil_bridge: AXI4-Lite slave turning each transaction into one async SRAM access
module sram_axil_bridge
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int SRAM_AW = 18,
    parameter int WAIT_CYCLES = WAIT_DEFAULT
) (
    input  logic                s00_axi_aclk,
    input  logic                s00_axi_aresetn,
    input  logic [ADDR_W-1:0]   s00_axi_awaddr,
    input  logic [2:0]          s00_axi_awprot,
    input  logic                s00_axi_awvalid,
    output logic                s00_axi_awready,
    input  logic [31:0]         s00_axi_wdata,
    input  logic [3:0]          s00_axi_wstrb,
    input  logic                s00_axi_wvalid,
    output logic                s00_axi_wready,
    output logic [1:0]          s00_axi_bresp,
    output logic                s00_axi_bvalid,
    input  logic                s00_axi_bready,
    input  logic [ADDR_W-1:0]   s00_axi_araddr,
    input  logic [2:0]          s00_axi_arprot,
    input  logic                s00_axi_arvalid,
    output logic                s00_axi_arready,
    output logic [31:0]         s00_axi_rdata,
    output logic [1:0]          s00_axi_rresp,
    output logic                s00_axi_rvalid,
    input  logic                s00_axi_rready,
    output logic [SRAM_AW-1:0]  sram_addr,
    output logic [31:0]         sram_dq_o,
    output logic                sram_dq_oe,
    input  logic [31:0]         sram_dq_i,
    output logic                sram_ce_n,
    output logic                sram_we_n,
    output logic                sram_oe_n,
    output logic [3:0]          sram_be_n
);
    state_t state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic wr_acc, rd_acc, aw_oor, ar_oor, cnt_done, wr_busy;
    logic unused;

    assign unused = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};
    assign wr_acc = state == IDLE && s00_axi_awvalid && s00_axi_wvalid;
    assign rd_acc = state == IDLE && s00_axi_arvalid && !(s00_axi_awvalid && s00_axi_wvalid);
    assign aw_oor = |s00_axi_awaddr[ADDR_W-1:SRAM_AW+2];
    assign ar_oor = |s00_axi_araddr[ADDR_W-1:SRAM_AW+2];
    assign cnt_done = cnt == '0;
    assign wr_busy = state == WR_SETUP || state == WR_PULSE || state == WR_HOLD;

    // state register; reset drops straight to IDLE so strobes release asynchronously
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
        if (!s00_axi_aresetn) state <= IDLE;
        else state <= state_nxt;

    // next state; the write response is offered during the hold cycle and B_RESP only absorbs bready stalls
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      state_nxt = wr_acc ? ((aw_oor || s00_axi_wstrb == '0) ? B_RESP : WR_SETUP)
                                 : rd_acc ? (ar_oor ? R_RESP : RD_STROBE) : IDLE;
            WR_SETUP:  state_nxt = WR_PULSE;
            WR_PULSE:  state_nxt = cnt_done ? WR_HOLD : WR_PULSE;
            WR_HOLD:   state_nxt = s00_axi_bready ? IDLE : B_RESP;
            RD_STROBE: state_nxt = cnt_done ? R_RESP : RD_STROBE;
            B_RESP:    state_nxt = s00_axi_bready ? IDLE : B_RESP;
            R_RESP:    state_nxt = s00_axi_rready ? IDLE : R_RESP;
            default:   state_nxt = IDLE;
        endcase
    end

    // wait counter reloads outside the strobe states and runs down while strobing
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
        if (!s00_axi_aresetn) cnt <= '0;
        else cnt <= (state == WR_PULSE || state == RD_STROBE) ? cnt - 1'b1 : CNT_W'(WAIT_CYCLES);

    // latch address, data, lanes and response at acceptance; capture read data on the last strobe cycle
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn)
        if (!s00_axi_aresetn) begin
            sram_addr <= '0;
            sram_dq_o <= '0;
            sram_be_n <= 4'hF;
            s00_axi_bresp <= RESP_OKAY;
            s00_axi_rresp <= RESP_OKAY;
            s00_axi_rdata <= '0;
        end else if (wr_acc) begin
            sram_addr <= s00_axi_awaddr[SRAM_AW+1:2];
            sram_dq_o <= s00_axi_wdata;
            sram_be_n <= ~s00_axi_wstrb;
            s00_axi_bresp <= aw_oor ? RESP_SLVERR : RESP_OKAY;
        end else if (rd_acc) begin
            sram_addr <= s00_axi_araddr[SRAM_AW+1:2];
            sram_be_n <= 4'h0;
            s00_axi_rresp <= ar_oor ? RESP_SLVERR : RESP_OKAY;
            s00_axi_rdata <= '0;
        end else if (state == RD_STROBE && cnt_done) begin
            s00_axi_rdata <= sram_dq_i;
        end

    // handshakes and SRAM strobes decoded from the current state
    always_comb begin
        s00_axi_awready = wr_acc;
        s00_axi_wready = wr_acc;
        s00_axi_arready = rd_acc;
        s00_axi_bvalid = state == WR_HOLD || state == B_RESP;
        s00_axi_rvalid = state == R_RESP;
        sram_dq_oe = wr_busy;
        sram_we_n = state != WR_PULSE;
        sram_oe_n = state != RD_STROBE;
        sram_ce_n = !(wr_busy || state == RD_STROBE);
    end
endmodule
